// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM states
// and the width of the wait-state counter.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACCESS,
        ST_RESP
    } state_t;

    localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/dmem_array.sv
// Single-port synchronous RAM, DEPTH_WORDS x 32, per-byte write enables and a
// registered read port (read-before-write when both happen on one edge).
module dmem_array #(
    parameter int DEPTH_WORDS = 262144,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Data-memory load/store unit: request/response handshake, optional wait states,
// byte/half/word lane steering with extension. Define DMEM_MISALIGN_TRAP_EN to fault misaligned accesses.
module dmem_lsu
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 262144,
    parameter int ADDR_W      = 32,
    parameter int WAIT_STATES = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [ADDR_W-1:0] RANGE_MASK = ADDR_W'(longint'(DEPTH_WORDS) * 4 - 1);

    state_t                state;
    logic [WAIT_CNT_W-1:0] wait_cnt;
    logic                  accept;
    logic [1:0]            dec_lane;
    logic                  dec_err;

    logic                  lat_we;
    logic [1:0]            lat_size;
    logic                  lat_uns;
    logic [1:0]            lat_lane;
    logic [IDX_W-1:0]      lat_idx;
    logic [31:0]           lat_wdata;
    logic                  lat_err;

    logic [3:0]            be;
    logic [31:0]           wr_word;
    logic [31:0]           arr_rdata;
    logic [31:0]           shifted;
    logic [31:0]           load_ext;

    assign accept = (state == ST_IDLE) && req_valid && req_ready;

    // Sub-word accesses snap to their natural lane; the trap build faults instead.
    always_comb begin
        dec_lane = req_addr[1:0];
        case (req_size)
            SZ_HALF: dec_lane = {req_addr[1], 1'b0};
            SZ_WORD: dec_lane = 2'b00;
            default: dec_lane = req_addr[1:0];
        endcase
    end

`ifdef DMEM_MISALIGN_TRAP_EN
    logic misalign;
    assign misalign = ((req_size == SZ_HALF) && req_addr[0]) ||
                      ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));
    assign dec_err  = (|(req_addr & ~RANGE_MASK)) || (req_size == SZ_RSVD) || misalign;
`else
    assign dec_err  = (|(req_addr & ~RANGE_MASK)) || (req_size == SZ_RSVD);
`endif

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we    <= req_we;
            lat_size  <= req_size;
            lat_uns   <= req_unsigned;
            lat_lane  <= dec_lane;
            lat_idx   <= req_addr[IDX_W+1:2];
            lat_wdata <= req_wdata;
            lat_err   <= dec_err;
        end
    end

    always_comb begin
        be      = 4'b1111;
        wr_word = lat_wdata;
        case (lat_size)
            SZ_BYTE: begin
                be      = 4'b0001 << lat_lane;
                wr_word = {4{lat_wdata[7:0]}};
            end
            SZ_HALF: begin
                be      = lat_lane[1] ? 4'b1100 : 4'b0011;
                wr_word = {2{lat_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (state == ST_ACCESS),
        .we    (lat_we),
        .be    (be),
        .idx   (lat_idx),
        .wdata (wr_word),
        .rdata (arr_rdata)
    );

    always_comb begin
        shifted = arr_rdata >> {lat_lane, 3'b000};
        case (lat_size)
            SZ_BYTE: load_ext = lat_uns ? {24'h0, shifted[7:0]}
                                        : {{24{shifted[7]}}, shifted[7:0]};
            SZ_HALF: load_ext = lat_uns ? {16'h0, shifted[15:0]}
                                        : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = arr_rdata;
        endcase
    end

    // RESP spends its first cycle registering the response, so the array read settles first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        req_ready <= 1'b0;
                        if (dec_err) begin
                            state <= ST_RESP;
                        end else if (WAIT_STATES > 0) begin
                            state    <= ST_WAIT;
                            wait_cnt <= WAIT_CNT_W'(WAIT_STATES - 1);
                        end else begin
                            state <= ST_ACCESS;
                        end
                    end
                end
                ST_WAIT: begin
                    if (wait_cnt == '0) state <= ST_ACCESS;
                    else                wait_cnt <= wait_cnt - 1'b1;
                end
                ST_ACCESS: state <= ST_RESP;
                ST_RESP: begin
                    if (!rsp_valid) begin
                        rsp_valid <= 1'b1;
                        rsp_err   <= lat_err;
                        rsp_rdata <= (lat_err || lat_we) ? 32'h0 : load_ext;
                    end else if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rsp_err   <= 1'b0;
                        rsp_rdata <= 32'h0;
                        req_ready <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
